// File: rtl/mem_arbiter_if.sv
// Bundles the fetch (I), memory-access (D) and memory-side signals of the arbiter.
// Latency: none, wires only.
// Backpressure: carried by i_ready/d_ready toward requesters and m_ready from memory.
interface mem_arbiter_if;
    logic        i_start;
    logic        i_ready;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_valid;

    logic        d_start;
    logic        d_ready;
    logic [31:0] d_addr;
    logic        d_wen;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;

    logic        m_start;
    logic        m_ready;
    logic [31:0] m_addr;
    logic        m_wen;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_valid;

    // The arbiter drives the memory request and both requester responses.
    modport master (
        input  i_start, i_addr,
        output i_ready, i_rdata, i_valid,
        input  d_start, d_addr, d_wen, d_wdata,
        output d_ready, d_rdata, d_valid,
        output m_start, m_addr, m_wen, m_wdata,
        input  m_ready, m_rdata, m_valid
    );

    // Requesters plus memory as seen from the surrounding pipeline.
    modport slave (
        output i_start, i_addr,
        input  i_ready, i_rdata, i_valid,
        output d_start, d_addr, d_wen, d_wdata,
        input  d_ready, d_rdata, d_valid,
        input  m_start, m_addr, m_wen, m_wdata,
        output m_ready, m_rdata, m_valid
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch (I) and memory-access (D); D has priority, I is forced after STARVE_LIMIT D grants.
// Latency: start captured at one edge, m_start issued the next edge; response routed combinationally.
// Backpressure: a port drops starts while not ready; grants wait for m_ready; one request in flight.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.master bus
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    state_t        state_q, state_d;
    owner_t        owner_q;
    logic [SW-1:0] starve_q, starve_d;

    logic          i_pend_q;
    logic [31:0]   i_addr_q;
    logic          d_pend_q;
    logic [31:0]   d_addr_q;
    logic          d_wen_q;
    logic [31:0]   d_wdata_q;

    logic          m_start_q;
    logic [31:0]   m_addr_q;
    logic          m_wen_q;
    logic [31:0]   m_wdata_q;

    logic          grant_i;
    logic          grant_d;
    logic          i_rdy;
    logic          d_rdy;
    logic          i_acc;
    logic          d_acc;

    // A port is busy while it holds a pending request or owns the in-flight one.
    assign i_rdy = !i_pend_q && !(state_q == ST_WAIT && owner_q == OWN_I);
    assign d_rdy = !d_pend_q && !(state_q == ST_WAIT && owner_q == OWN_D);
    assign i_acc = bus.i_start && i_rdy;
    assign d_acc = bus.d_start && d_rdy;

    always_comb begin
        state_d = state_q;
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state_q == ST_IDLE) begin
            if ((i_pend_q || d_pend_q) && bus.m_ready) begin
                if (i_pend_q && (!d_pend_q || starve_q == STARVE_MAX)) begin
                    grant_i = 1'b1;
                end else begin
                    grant_d = 1'b1;
                end
                state_d = ST_WAIT;
            end
        end else begin
            if (bus.m_valid) begin
                state_d = ST_IDLE;
            end
        end
    end

    // Count only D grants that actually bypass a waiting fetch.
    always_comb begin
        starve_d = starve_q;
        if (grant_i || !i_pend_q) begin
            starve_d = '0;
        end else if (grant_d && starve_q != STARVE_MAX) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWN_I;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            if (grant_i) begin
                owner_q <= OWN_I;
            end else if (grant_d) begin
                owner_q <= OWN_D;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_pend_q  <= 1'b0;
            i_addr_q  <= '0;
            d_pend_q  <= 1'b0;
            d_addr_q  <= '0;
            d_wen_q   <= 1'b0;
            d_wdata_q <= '0;
        end else begin
            if (i_acc) begin
                i_pend_q <= 1'b1;
                i_addr_q <= bus.i_addr;
            end else if (grant_i) begin
                i_pend_q <= 1'b0;
            end
            if (d_acc) begin
                d_pend_q  <= 1'b1;
                d_addr_q  <= bus.d_addr;
                d_wen_q   <= bus.d_wen;
                d_wdata_q <= bus.d_wdata;
            end else if (grant_d) begin
                d_pend_q <= 1'b0;
            end
        end
    end

    // Request fields stay put from the grant until the next grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_start_q <= 1'b0;
            m_addr_q  <= '0;
            m_wen_q   <= 1'b0;
            m_wdata_q <= '0;
        end else begin
            m_start_q <= grant_i || grant_d;
            if (grant_i) begin
                m_addr_q  <= i_addr_q;
                m_wen_q   <= 1'b0;
                m_wdata_q <= '0;
            end else if (grant_d) begin
                m_addr_q  <= d_addr_q;
                m_wen_q   <= d_wen_q;
                m_wdata_q <= d_wdata_q;
            end
        end
    end

    assign bus.i_ready = i_rdy;
    assign bus.d_ready = d_rdy;
    assign bus.m_start = m_start_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wen   = m_wen_q;
    assign bus.m_wdata = m_wdata_q;

    // A response in IDLE belongs to nobody and is discarded.
    assign bus.i_valid = bus.m_valid && state_q == ST_WAIT && owner_q == OWN_I;
    assign bus.d_valid = bus.m_valid && state_q == ST_WAIT && owner_q == OWN_D;
    assign bus.i_rdata = bus.m_rdata;
    assign bus.d_rdata = bus.m_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference model compared every cycle.
// Latency: inputs driven 1ns after the rising edge, model outputs compared on the falling edge.
// Backpressure: m_ready and m_valid are driven directly by the stimulus.
module tb_mem_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int mstart_cnt = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: port 0 = fetch, port 1 = data.
    bit          mp[2]  = '{0, 0};
    logic [31:0] ma[2]  = '{0, 0};
    bit          mw[2]  = '{0, 0};
    logic [31:0] md[2]  = '{0, 0};
    bit          m_busy = 0;
    int          m_own  = 0;
    int          m_starve = 0;
    bit          e_start = 0;
    logic [31:0] e_addr  = 0;
    bit          e_wen   = 0;
    logic [31:0] e_wdata = 0;

    bit          s_st[2];
    logic [31:0] s_a[2];
    bit          s_w[2];
    logic [31:0] s_wd[2];
    bit          s_rdy[2];
    int          win;

    function automatic bit model_ready(int p);
        return !mp[p] && !(m_busy && m_own == p);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                mp[p] = 0; ma[p] = 0; mw[p] = 0; md[p] = 0;
            end
            m_busy = 0; m_own = 0; m_starve = 0;
            e_start = 0; e_addr = 0; e_wen = 0; e_wdata = 0;
        end else begin
            s_st[0] = bus.i_start; s_a[0] = bus.i_addr; s_w[0] = 0;         s_wd[0] = 0;
            s_st[1] = bus.d_start; s_a[1] = bus.d_addr; s_w[1] = bus.d_wen; s_wd[1] = bus.d_wdata;
            for (int p = 0; p < 2; p++) s_rdy[p] = model_ready(p);
            win = -1;
            if (m_busy) begin
                if (bus.m_valid) m_busy = 0;
            end else if ((mp[0] || mp[1]) && bus.m_ready) begin
                win = (mp[0] && (!mp[1] || m_starve == 4)) ? 0 : 1;
            end
            if (!mp[0] || win == 0) m_starve = 0;
            else if (win == 1) m_starve = (m_starve < 4) ? m_starve + 1 : 4;
            e_start = (win >= 0);
            if (win >= 0) begin
                m_busy  = 1;
                m_own   = win;
                e_addr  = ma[win];
                e_wen   = mw[win];
                e_wdata = md[win];
                mp[win] = 0;
            end
            for (int p = 0; p < 2; p++) begin
                if (s_st[p] && s_rdy[p]) begin
                    mp[p] = 1; ma[p] = s_a[p]; mw[p] = s_w[p]; md[p] = s_wd[p];
                end
            end
        end
    end

    always @(negedge clk) begin
        chk1 ("i_ready", bus.i_ready, model_ready(0));
        chk1 ("d_ready", bus.d_ready, model_ready(1));
        chk1 ("i_valid", bus.i_valid, bus.m_valid && m_busy && m_own == 0);
        chk1 ("d_valid", bus.d_valid, bus.m_valid && m_busy && m_own == 1);
        chk32("i_rdata", bus.i_rdata, bus.m_rdata);
        chk32("d_rdata", bus.d_rdata, bus.m_rdata);
        chk1 ("m_start", bus.m_start, e_start);
        chk32("m_addr",  bus.m_addr,  e_addr);
        chk1 ("m_wen",   bus.m_wen,   e_wen);
        chk32("m_wdata", bus.m_wdata, e_wdata);
        if (bus.m_start === 1'b1) mstart_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int base;

    initial begin
        bus.i_start = 0; bus.i_addr = 0;
        bus.d_start = 0; bus.d_addr = 0; bus.d_wen = 0; bus.d_wdata = 0;
        bus.m_ready = 1; bus.m_rdata = 0; bus.m_valid = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        #2;
        chk1 ("rst_i_ready", bus.i_ready, 1'b1);
        chk1 ("rst_d_ready", bus.d_ready, 1'b1);
        chk1 ("rst_m_start", bus.m_start, 1'b0);
        chk32("rst_m_addr",  bus.m_addr,  32'h0);

        // Single fetch
        tick; bus.i_start = 1; bus.i_addr = 32'h100;
        tick; bus.i_start = 0;
        #2 chk1("t1_i_busy", bus.i_ready, 1'b0); chk1("t1_not_yet", bus.m_start, 1'b0);
        tick;
        #2 chk1("t1_start", bus.m_start, 1'b1); chk32("t1_addr", bus.m_addr, 32'h100); chk1("t1_wen", bus.m_wen, 1'b0);
        tick; bus.m_valid = 1; bus.m_rdata = 32'h33;
        #2 chk1("t1_pulse", bus.m_start, 1'b0); chk1("t1_i_valid", bus.i_valid, 1'b1);
        chk32("t1_i_rdata", bus.i_rdata, 32'h33); chk1("t1_d_valid", bus.d_valid, 1'b0);
        tick; bus.m_valid = 0;
        #2 chk1("t1_i_ready_back", bus.i_ready, 1'b1);

        // Simultaneous starts: D first, then I
        tick; bus.i_start = 1; bus.i_addr = 32'h0;
        bus.d_start = 1; bus.d_addr = 32'h200; bus.d_wen = 1; bus.d_wdata = 32'hAB;
        tick; bus.i_start = 0; bus.d_start = 0; bus.d_wen = 0; bus.d_wdata = 0;
        tick;
        #2 chk1("t2_d_start", bus.m_start, 1'b1); chk32("t2_d_addr", bus.m_addr, 32'h200);
        chk1("t2_d_wen", bus.m_wen, 1'b1); chk32("t2_d_wdata", bus.m_wdata, 32'hAB);
        tick; bus.m_valid = 1;
        #2 chk1("t2_d_valid", bus.d_valid, 1'b1); chk1("t2_i_quiet", bus.i_valid, 1'b0);
        tick; bus.m_valid = 0;
        #2 chk1("t2_gap", bus.m_start, 1'b0);
        tick;
        #2 chk1("t2_i_start", bus.m_start, 1'b1); chk32("t2_i_addr", bus.m_addr, 32'h0);
        chk1("t2_i_wen", bus.m_wen, 1'b0); chk32("t2_i_wdata", bus.m_wdata, 32'h0);
        tick; bus.m_valid = 1;
        #2 chk1("t2_i_valid", bus.i_valid, 1'b1);
        tick; bus.m_valid = 0;

        // Starvation: four D grants bypass a waiting fetch, the fifth grant goes to I
        tick; bus.m_ready = 0; bus.i_start = 1; bus.i_addr = 32'h300;
        tick; bus.i_start = 0; bus.d_start = 1; bus.d_addr = 32'h400;
        for (int r = 0; r < 5; r++) begin
            tick; bus.d_start = 0; bus.m_ready = 1;
            tick; bus.m_ready = 0;
            #2 chk1("t3_start", bus.m_start, 1'b1);
            chk32("t3_addr", bus.m_addr, (r < 4) ? 32'h400 + 32'(r) : 32'h300);
            tick; bus.m_valid = 1;
            #2 chk1("t3_d_valid", bus.d_valid, r < 4); chk1("t3_i_valid", bus.i_valid, r == 4);
            tick; bus.m_valid = 0;
            if (r < 4) begin
                bus.d_start = 1; bus.d_addr = 32'h400 + 32'(r + 1);
            end
        end
        bus.d_start = 0; bus.m_ready = 1;
        tick;
        #2 chk1("t3_tail_start", bus.m_start, 1'b1); chk32("t3_tail_addr", bus.m_addr, 32'h404);
        tick; bus.m_valid = 1;
        #2 chk1("t3_tail_valid", bus.d_valid, 1'b1);
        tick; bus.m_valid = 0;

        // Memory not ready for ten cycles, with a spurious response in IDLE
        tick; bus.m_ready = 0; bus.i_start = 1; bus.i_addr = 32'h500;
        tick; bus.i_start = 0;
        for (int k = 0; k < 10; k++) begin
            tick;
            bus.m_valid = (k == 4);
            if (k == 9) bus.m_ready = 1;
            #2 chk1("t4_held", bus.m_start, 1'b0);
            if (k == 4) begin
                chk1("t4_spur_i", bus.i_valid, 1'b0);
                chk1("t4_spur_d", bus.d_valid, 1'b0);
            end
        end
        tick;
        #2 chk1("t4_start", bus.m_start, 1'b1); chk32("t4_addr", bus.m_addr, 32'h500);
        tick; bus.m_valid = 1;
        #2 chk1("t4_i_valid", bus.i_valid, 1'b1);
        tick; bus.m_valid = 0;

        // Reset while a D write is in flight
        tick; bus.d_start = 1; bus.d_addr = 32'h600; bus.d_wen = 1; bus.d_wdata = 32'h5;
        tick; bus.d_start = 0; bus.d_wen = 0; bus.d_wdata = 0;
        tick;
        #2 chk1("t5_start", bus.m_start, 1'b1); chk1("t5_wen", bus.m_wen, 1'b1);
        tick;
        #2 rst_n = 0;
        #1 chk1("t5_rst_start", bus.m_start, 1'b0); chk32("t5_rst_addr", bus.m_addr, 32'h0);
        chk1("t5_rst_wen", bus.m_wen, 1'b0); chk32("t5_rst_wdata", bus.m_wdata, 32'h0);
        bus.m_valid = 1;
        #1 chk1("t5_rst_d_valid", bus.d_valid, 1'b0);
        tick; rst_n = 1;
        #2 chk1("t5_i_ready", bus.i_ready, 1'b1); chk1("t5_d_ready", bus.d_ready, 1'b1);
        chk1("t5_late_d", bus.d_valid, 1'b0); chk1("t5_late_i", bus.i_valid, 1'b0);
        tick; bus.m_valid = 0;
        #2 chk1("t5_no_reissue", bus.m_start, 1'b0);

        // Start while not ready is dropped
        base = mstart_cnt;
        tick; bus.i_start = 1; bus.i_addr = 32'h700;
        tick; bus.i_addr = 32'h704;
        #2 chk1("t6_not_ready", bus.i_ready, 1'b0);
        tick; bus.i_start = 0;
        #2 chk1("t6_start", bus.m_start, 1'b1); chk32("t6_addr", bus.m_addr, 32'h700);
        tick;
        tick; bus.m_valid = 1;
        #2 chk1("t6_i_valid", bus.i_valid, 1'b1);
        tick; bus.m_valid = 0;
        tick;
        tick;
        #2 chk32("t6_one_txn", 32'(mstart_cnt - base), 32'd1);

        tick;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
